// File: rtl/reg_file_pkg.sv
// Shared sizing for the register file: default width/depth exponents and the
// derived sizes, reused by the interface and the core.
package reg_file_pkg;

    localparam int REG_DATA_WIDTH_POW_DEF = 6;
    localparam int REG_MEM_DEPTH_POW_DEF  = 5;
    localparam int REG_DATA_WIDTH_DEF     = 2 ** REG_DATA_WIDTH_POW_DEF;
    localparam int REG_MEM_DEPTH_DEF      = 2 ** REG_MEM_DEPTH_POW_DEF;

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// Read/write port bundle of the register file: two read indices, one write port,
// and the two read data returns.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = REG_DATA_WIDTH_POW_DEF,
    parameter int REG_MEM_DEPTH_POW  = REG_MEM_DEPTH_POW_DEF
);

    localparam int REG_DATA_WIDTH = 2 ** REG_DATA_WIDTH_POW;

    logic [REG_MEM_DEPTH_POW-1:0] rs1_in;
    logic [REG_MEM_DEPTH_POW-1:0] rs2_in;
    logic [REG_MEM_DEPTH_POW-1:0] rd_in;
    logic [REG_DATA_WIDTH-1:0]    data_write;
    logic                         write_en;
    logic [REG_DATA_WIDTH-1:0]    reg_data1_out;
    logic [REG_DATA_WIDTH-1:0]    reg_data2_out;

    modport master (
        output rs1_in,
        output rs2_in,
        output rd_in,
        output data_write,
        output write_en,
        input  reg_data1_out,
        input  reg_data2_out
    );

    modport slave (
        input  rs1_in,
        input  rs2_in,
        input  rd_in,
        input  data_write,
        input  write_en,
        output reg_data1_out,
        output reg_data2_out
    );

endinterface : reg_file_if

// File: rtl/reg_file.sv
// Two-read/one-write register file with a hard-wired zero register, combinational
// reads (no write bypass) and an asynchronous clear of every register.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = REG_DATA_WIDTH_POW_DEF,
    parameter int REG_MEM_DEPTH_POW  = REG_MEM_DEPTH_POW_DEF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    reg_file_if.slave  bus
);

    localparam int REG_DATA_WIDTH = 2 ** REG_DATA_WIDTH_POW;
    localparam int REG_MEM_DEPTH  = 2 ** REG_MEM_DEPTH_POW;

    logic [REG_DATA_WIDTH-1:0] mem_reg [REG_MEM_DEPTH];
    logic [REG_MEM_DEPTH-1:0]  wr_sel;

    // One-hot write select; entry 0 never selects, so writes to x0 vanish.
    genvar gi;
    generate
        for (gi = 0; gi < REG_MEM_DEPTH; gi++) begin : gen_wr_sel
            if (gi == 0) begin : gen_zero
                assign wr_sel[gi] = 1'b0;
            end else begin : gen_reg
                assign wr_sel[gi] = bus.write_en &&
                                    (bus.rd_in == REG_MEM_DEPTH_POW'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_MEM_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_MEM_DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= bus.data_write;
                end
            end
        end
    end

    // Reads see only committed state: a same-cycle write is not forwarded.
    assign bus.reg_data1_out = (bus.rs1_in == '0) ? '0 : mem_reg[bus.rs1_in];
    assign bus.reg_data2_out = (bus.rs2_in == '0) ? '0 : mem_reg[bus.rs2_in];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed-vector bench for reg_file: a table of pre-edge read expectations plus
// hand sequences for reset, read-after-write timing and asynchronous clear.
module tb_reg_file;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    reg_file_if bus_if ();

    reg_file dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus_if)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } vec_t;

    vec_t vecs [16];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic we, logic [4:0] rd, logic [63:0] wdata,
                                logic [4:0] rs1, logic [4:0] rs2,
                                logic [63:0] exp1, logic [63:0] exp2);
        vec_t v;
        v.we = we; v.rd = rd; v.wdata = wdata;
        v.rs1 = rs1; v.rs2 = rs2; v.exp1 = exp1; v.exp2 = exp2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [63:0] wdata,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus_if.write_en   = we;
        bus_if.rd_in      = rd;
        bus_if.data_write = wdata;
        bus_if.rs1_in     = rs1;
        bus_if.rs2_in     = rs2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Rows: inputs applied after negedge, outputs checked before the next posedge.
        vecs[0]  = mk(1, 3,  64'hDEADBEEFCAFEF00D, 3,  0,  64'h0, 64'h0);
        vecs[1]  = mk(0, 0,  64'h0,                3,  3,  64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D);
        vecs[2]  = mk(1, 0,  64'hFFFFFFFFFFFFFFFF, 0,  0,  64'h0, 64'h0);
        vecs[3]  = mk(0, 0,  64'h0,                0,  0,  64'h0, 64'h0);
        vecs[4]  = mk(1, 7,  64'h55,               7,  3,  64'h0, 64'hDEADBEEFCAFEF00D);
        vecs[5]  = mk(0, 7,  64'hAA,               3,  7,  64'hDEADBEEFCAFEF00D, 64'h55);
        vecs[6]  = mk(0, 7,  64'hAA,               3,  7,  64'hDEADBEEFCAFEF00D, 64'h55);
        vecs[7]  = mk(0, 7,  64'hAA,               3,  7,  64'hDEADBEEFCAFEF00D, 64'h55);
        vecs[8]  = mk(1, 1,  64'h11,               7,  7,  64'h55, 64'h55);
        vecs[9]  = mk(1, 2,  64'h22,               1,  1,  64'h11, 64'h11);
        vecs[10] = mk(1, 1,  64'h99,               2,  1,  64'h22, 64'h11);
        vecs[11] = mk(1, 31, 64'h0123456789ABCDEF, 1,  31, 64'h99, 64'h0);
        vecs[12] = mk(0, 0,  64'h0,                31, 1,  64'h0123456789ABCDEF, 64'h99);
        vecs[13] = mk(1, 31, 64'hFEDCBA9876543210, 31, 31, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
        vecs[14] = mk(0, 0,  64'h0,                31, 2,  64'hFEDCBA9876543210, 64'h22);
        vecs[15] = mk(0, 0,  64'h0,                3,  7,  64'hDEADBEEFCAFEF00D, 64'h55);

        // Reset held with a write pending: outputs stay 0, write ignored.
        drive(1, 5, 64'hFFFFFFFFFFFFFFFF, 5, 31);
        #1 rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        chk("reset_rd1", bus_if.reg_data1_out, 64'h0);
        chk("reset_rd2", bus_if.reg_data2_out, 64'h0);
        $display("reset: rd1=%h rd2=%h", bus_if.reg_data1_out, bus_if.reg_data2_out);
        drive(0, 0, 64'h0, 0, 0);
        rst_in = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in);
            drive(vecs[i].we, vecs[i].rd, vecs[i].wdata, vecs[i].rs1, vecs[i].rs2);
            #1;
            $display("vec %0d: we=%0b rd=%0d wd=%h rs1=%0d rs2=%0d rd1=%h rd2=%h",
                     i, vecs[i].we, vecs[i].rd, vecs[i].wdata, vecs[i].rs1, vecs[i].rs2,
                     bus_if.reg_data1_out, bus_if.reg_data2_out);
            chk($sformatf("vec%0d_rd1", i), bus_if.reg_data1_out, vecs[i].exp1);
            chk($sformatf("vec%0d_rd2", i), bus_if.reg_data2_out, vecs[i].exp2);
        end

        // Read-after-write: old value before the edge, new value just after it.
        @(negedge clk_in);
        drive(1, 5, 64'h5555AAAA5555AAAA, 5, 5);
        #1;
        chk("raw_pre", bus_if.reg_data1_out, 64'h0);
        @(posedge clk_in);
        #1;
        chk("raw_post_rd1", bus_if.reg_data1_out, 64'h5555AAAA5555AAAA);
        chk("raw_post_rd2", bus_if.reg_data2_out, 64'h5555AAAA5555AAAA);
        $display("raw: rd1=%h rd2=%h", bus_if.reg_data1_out, bus_if.reg_data2_out);

        // Asynchronous clear between edges.
        @(negedge clk_in);
        drive(0, 0, 64'h0, 3, 31);
        #1;
        chk("pre_arst_rd1", bus_if.reg_data1_out, 64'hDEADBEEFCAFEF00D);
        chk("pre_arst_rd2", bus_if.reg_data2_out, 64'hFEDCBA9876543210);
        rst_in = 1'b1;
        #1;
        chk("arst_rd1", bus_if.reg_data1_out, 64'h0);
        chk("arst_rd2", bus_if.reg_data2_out, 64'h0);
        $display("async reset: rd1=%h rd2=%h", bus_if.reg_data1_out, bus_if.reg_data2_out);
        #1 rst_in = 1'b0;

        // First edge after reset release accepts a write.
        drive(1, 4, 64'h77, 4, 5);
        #1;
        chk("post_rst_pre", bus_if.reg_data1_out, 64'h0);
        chk("post_rst_r5", bus_if.reg_data2_out, 64'h0);
        @(posedge clk_in);
        #1;
        chk("post_rst_write", bus_if.reg_data1_out, 64'h77);
        $display("post reset write: rd1=%h rd2=%h", bus_if.reg_data1_out, bus_if.reg_data2_out);
        @(negedge clk_in);
        drive(0, 0, 64'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file
